// File: rtl/mux_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mux_arbiter_pkg
// Shared definitions for the mux_arbiter block:
//   - FSM state encodings (IDLE=0, BUSY=1)
//   - requester index constants (A=0, B=1, C=2, D=3)
//   - round-robin pick and one-hot helper functions
// No ports (package).
// ---------------------------------------------------------------------------
package mux_arbiter_pkg;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_BUSY = 1'b1;

   localparam logic [1:0] REQ_A = 2'd0;
   localparam logic [1:0] REQ_B = 2'd1;
   localparam logic [1:0] REQ_C = 2'd2;
   localparam logic [1:0] REQ_D = 2'd3;

   // First asserted request scanning last+1, last+2, last+3, last+4 (mod 4).
   // Returns last when nothing is requested; callers gate on |req.
   function automatic logic [1:0] rr_pick(input logic [3:0] req_vec,
                                          input logic [1:0] last);
      logic [1:0] idx;
      logic       found;
      rr_pick = last;
      found   = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         idx = last + k[1:0];
         if (!found && req_vec[idx]) begin
            rr_pick = idx;
            found   = 1'b1;
         end
      end
   endfunction

   function automatic logic [3:0] onehot4(input logic [1:0] idx);
      onehot4 = 4'b0001 << idx;
   endfunction

endpackage

// File: rtl/mux_arbiter_mux_4to1.sv
// ---------------------------------------------------------------------------
// mux_4to1
// Plain combinational 4:1 multiplexer, N bits wide.
// Ports:
//   i_sel   in  2  select (0->i_d0 .. 3->i_d3)
//   i_d0..3 in  N  data inputs
//   o_data  out N  selected data
// ---------------------------------------------------------------------------
module mux_4to1 #(
   parameter int N = 32
) (
   input  logic [1:0]   i_sel,
   input  logic [N-1:0] i_d0,
   input  logic [N-1:0] i_d1,
   input  logic [N-1:0] i_d2,
   input  logic [N-1:0] i_d3,
   output logic [N-1:0] o_data
);

   always_comb begin
      o_data = i_d0;
      case (i_sel)
         2'd0: o_data = i_d0;
         2'd1: o_data = i_d1;
         2'd2: o_data = i_d2;
         2'd3: o_data = i_d3;
         default: o_data = i_d0;
      endcase
   end

endmodule

// File: rtl/mux_arbiter.sv
// ---------------------------------------------------------------------------
// mux_arbiter
// Four-requester round-robin arbiter driving a 4:1 data mux. An owner keeps
// the grant until it drops its request or completes MAX_BEATS transfers;
// each release is followed by one IDLE arbitration cycle.
//
// Optional feature: macro MUX_ARBITER_LOCK_EN adds input 'lock'. While
// lock[sel] is high the MAX_BEATS release is suppressed (beat count
// saturates at 255).
//
// Ports:
//   clk          in  1  rising-edge clock
//   rst          in  1  asynchronous active-high reset
//   req          in  4  per-requester request (A=0 .. D=3)
//   A, B, C, D   in  N  requester data buses
//   out_ready    in  1  downstream accepts a beat
//   lock         in  4  (MUX_ARBITER_LOCK_EN only) burst lock per requester
//   out_valid    out 1  beat presented on out_data
//   out_data     out N  data of the bus selected by sel
//   grant        out 4  one-hot owner, zero when idle
//   sel          out 2  encoded owner / mux select
//   ack          out 4  one-hot pulse to owner on each accepted beat
//   o_dbg_state  out 1  FSM state (0=IDLE, 1=BUSY)
//
// Handshake: a beat transfers in any cycle where out_valid && out_ready are
// both high; out_valid never depends on out_ready.
// ---------------------------------------------------------------------------
module mux_arbiter
   import mux_arbiter_pkg::*;
#(
   parameter int N         = 32,
   parameter int MAX_BEATS = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [3:0]   req,
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
   input  logic [N-1:0] C,
   input  logic [N-1:0] D,
   input  logic         out_ready,
`ifdef MUX_ARBITER_LOCK_EN
   input  logic [3:0]   lock,
`endif
   output logic         out_valid,
   output logic [N-1:0] out_data,
   output logic [3:0]   grant,
   output logic [1:0]   sel,
   output logic [3:0]   ack,
   output logic         o_dbg_state
);

   logic [0:0] r_state;
   logic [3:0] r_grant;
   logic [1:0] r_sel;
   logic [1:0] r_last_winner;
   logic [7:0] r_beat_cnt;

   logic       w_valid;
   logic       w_xfer;
   logic       w_locked;
   logic       w_limit;
   logic [8:0] w_cnt_inc;
   logic [1:0] w_pick;

   assign w_valid   = (r_state == ST_BUSY) && req[r_sel];
   assign w_xfer    = w_valid && out_ready;
   assign w_cnt_inc = {1'b0, r_beat_cnt} + 9'd1;
   assign w_pick    = rr_pick(req, r_last_winner);

`ifdef MUX_ARBITER_LOCK_EN
   assign w_locked = lock[r_sel];
`else
   assign w_locked = 1'b0;
`endif

   // >= rather than == so that a burst that ran past MAX_BEATS while locked
   // releases on its first transfer after the lock drops.
   assign w_limit = (w_cnt_inc >= 9'(MAX_BEATS)) && !w_locked;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= ST_IDLE;
         r_grant       <= 4'b0000;
         r_sel         <= REQ_A;
         r_last_winner <= REQ_D;
         r_beat_cnt    <= 8'd0;
      end else if (r_state == ST_IDLE) begin
         if (|req) begin
            r_state       <= ST_BUSY;
            r_grant       <= onehot4(w_pick);
            r_sel         <= w_pick;
            r_last_winner <= w_pick;
            r_beat_cnt    <= 8'd0;
         end
      end else begin
         if (!req[r_sel]) begin
            r_state <= ST_IDLE;
            r_grant <= 4'b0000;
         end else if (w_xfer) begin
            if (w_limit) begin
               r_state <= ST_IDLE;
               r_grant <= 4'b0000;
            end
            r_beat_cnt <= (r_beat_cnt == 8'hFF) ? 8'hFF : w_cnt_inc[7:0];
         end
      end
   end

   mux_4to1 #(.N(N)) u_mux (
      .i_sel  (r_sel),
      .i_d0   (A),
      .i_d1   (B),
      .i_d2   (C),
      .i_d3   (D),
      .o_data (out_data)
   );

   assign out_valid   = w_valid;
   assign grant       = r_grant;
   assign sel         = r_sel;
   assign ack         = w_xfer ? onehot4(r_sel) : 4'b0000;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mux_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mux_arbiter
// Directed self-checking bench for mux_arbiter (N=32, MAX_BEATS=4).
// Inputs change 1 time unit after a rising edge; outputs are checked 1 unit
// after that.
// ---------------------------------------------------------------------------
module tb_mux_arbiter;

   logic        clk;
   logic        rst;
   logic [3:0]  req;
   logic [31:0] A, B, C, D;
   logic        out_ready;
`ifdef MUX_ARBITER_LOCK_EN
   logic [3:0]  lock;
`endif
   logic        out_valid;
   logic [31:0] out_data;
   logic [3:0]  grant;
   logic [1:0]  sel;
   logic [3:0]  ack;
   logic        dbg_state;

   int n_checks = 0;
   int n_bad    = 0;

   logic [31:0] bus_val [4];
   int          rr_order [5];

   mux_arbiter #(.N(32), .MAX_BEATS(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .req         (req),
      .A           (A),
      .B           (B),
      .C           (C),
      .D           (D),
      .out_ready   (out_ready),
`ifdef MUX_ARBITER_LOCK_EN
      .lock        (lock),
`endif
      .out_valid   (out_valid),
      .out_data    (out_data),
      .grant       (grant),
      .sel         (sel),
      .ack         (ack),
      .o_dbg_state (dbg_state)
   );

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Holds reset across two edges, then releases it just after an edge so the
   // next rising edge is the first arbitration.
   task automatic do_reset();
      rst       = 1'b1;
      req       = 4'b0000;
      out_ready = 1'b0;
`ifdef MUX_ARBITER_LOCK_EN
      lock      = 4'b0000;
`endif
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      bus_val[0] = 32'h0A; bus_val[1] = 32'h0B;
      bus_val[2] = 32'h0C; bus_val[3] = 32'h0D;
      rr_order[0] = 0; rr_order[1] = 1; rr_order[2] = 2;
      rr_order[3] = 3; rr_order[4] = 0;
      A = bus_val[0]; B = bus_val[1]; C = bus_val[2]; D = bus_val[3];
`ifdef MUX_ARBITER_LOCK_EN
      lock = 4'b0000;
`endif

      // ---- reset with all requesters asking ----
      rst = 1'b1; req = 4'b1111; out_ready = 1'b1;
      tick(); tick();
      chk("rst_grant", {28'd0, grant}, 32'h0);
      chk("rst_valid", {31'd0, out_valid}, 32'h0);
      chk("rst_sel",   {30'd0, sel}, 32'h0);
      chk("rst_ack",   {28'd0, ack}, 32'h0);
      chk("rst_state", {31'd0, dbg_state}, 32'h0);
      chk("rst_data",  out_data, 32'h0A);
      rst = 1'b0;
      tick();
      chk("rel_grant", {28'd0, grant}, 32'h1);

      // ---- round robin, 4 beats per owner, one idle cycle between ----
      for (int g = 0; g < 5; g++) begin
         for (int b = 0; b < 4; b++) begin
            chk($sformatf("rr%0d_b%0d_grant", g, b), {28'd0, grant}, 32'(1 << rr_order[g]));
            chk($sformatf("rr%0d_b%0d_ack", g, b),   {28'd0, ack},   32'(1 << rr_order[g]));
            chk($sformatf("rr%0d_b%0d_data", g, b),  out_data, bus_val[rr_order[g]]);
            tick();
         end
         chk($sformatf("rr%0d_idle_grant", g), {28'd0, grant}, 32'h0);
         chk($sformatf("rr%0d_idle_valid", g), {31'd0, out_valid}, 32'h0);
         chk($sformatf("rr%0d_idle_state", g), {31'd0, dbg_state}, 32'h0);
         tick();
      end

      // ---- backpressure on owner 2 ----
      do_reset();
      req = 4'b0100; out_ready = 1'b0;
      tick();
      for (int c = 0; c < 10; c++) begin
         chk("bp_valid", {31'd0, out_valid}, 32'h1);
         chk("bp_data",  out_data, 32'h0C);
         chk("bp_ack",   {28'd0, ack}, 32'h0);
         chk("bp_grant", {28'd0, grant}, 32'h4);
         tick();
      end
      out_ready = 1'b1;
      #1;
      chk("bp_ack_go", {28'd0, ack}, 32'h4);
      chk("bp_sel",    {30'd0, sel}, 32'h2);

      // ---- early release by owner 1, requester 2 waiting ----
      do_reset();
      req = 4'b0110; out_ready = 1'b1;
      tick();
      chk("er_grant", {28'd0, grant}, 32'h2);
      chk("er_ack1",  {28'd0, ack}, 32'h2);
      tick();
      chk("er_ack2",  {28'd0, ack}, 32'h2);
      tick();
      req = 4'b0100;
      #1;
      chk("er_drop_valid", {31'd0, out_valid}, 32'h0);
      chk("er_drop_ack",   {28'd0, ack}, 32'h0);
      tick();
      chk("er_idle_grant", {28'd0, grant}, 32'h0);
      tick();
      chk("er_next_grant", {28'd0, grant}, 32'h4);
      chk("er_next_data",  out_data, 32'h0C);

      // ---- reset in the middle of owner 3's burst ----
      do_reset();
      req = 4'b1000; out_ready = 1'b1;
      tick();
      chk("mr_grant", {28'd0, grant}, 32'h8);
      tick();
      tick();
      chk("mr_beat3_ack", {28'd0, ack}, 32'h8);
      rst = 1'b1;
      #1;
      chk("mr_abort_grant", {28'd0, grant}, 32'h0);
      chk("mr_abort_ack",   {28'd0, ack}, 32'h0);
      chk("mr_abort_valid", {31'd0, out_valid}, 32'h0);
      tick();
      rst = 1'b0;
      tick();
      chk("mr_regrant", {28'd0, grant}, 32'h8);
      chk("mr_sel",     {30'd0, sel}, 32'h3);

`ifdef MUX_ARBITER_LOCK_EN
      // ---- locked burst beyond MAX_BEATS ----
      do_reset();
      req = 4'b0001; lock = 4'b0001; out_ready = 1'b1;
      tick();
      for (int c = 0; c < 20; c++) begin
         chk("lk_ack",   {28'd0, ack}, 32'h1);
         chk("lk_grant", {28'd0, grant}, 32'h1);
         tick();
      end
      lock = 4'b0000;
      #1;
      chk("lk_last_ack", {28'd0, ack}, 32'h1);
      tick();
      chk("lk_release", {28'd0, grant}, 32'h0);
`endif

      $display("test done: total=%0d bad=%0d", n_checks, n_bad);
      $finish;
   end

endmodule
